// File: rtl/nios_mem_arb_pkg.sv
// Shared constants and types for the on-chip RAM port arbiter.
package nios_mem_arb_pkg;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   // Requester identity: M0 is the CPU data master, M1 the QSPI copy engine
   typedef enum logic {
      REQ_M0 = 1'b0,
      REQ_M1 = 1'b1
   } req_id_t;

   // Width needed to hold a burst count of 0..max_burst
   function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
      return $clog2(max_burst + 1);
   endfunction

   function automatic req_id_t other_req(input req_id_t r);
      return (r == REQ_M0) ? REQ_M1 : REQ_M0;
   endfunction

endpackage

// File: rtl/nios_mem_arb_grant.sv
// Sticky two-way grant with a fairness limit on consecutive grants.
module nios_mem_arb_grant
   import nios_mem_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req0,
   input  logic req1,
   output logic grant0,
   output logic grant1
);

   localparam int unsigned       CNT_W   = burst_cnt_w(MAX_BURST);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

   req_id_t          last_grant;
   logic [CNT_W-1:0] burst_cnt;
   logic             fresh;
   req_id_t          winner;
   logic             any_accept;

   // Pick the winner this cycle; a grant is only ever given to a requester
   always_comb begin
      winner = REQ_M0;
      if (req0 && req1) begin
         // Until the first transfer after reset, the side opposite last_grant
         // (M0) wins; afterwards the owner keeps the port until the limit.
         if (fresh)
            winner = other_req(last_grant);
         else if (burst_cnt < CNT_MAX)
            winner = last_grant;
         else
            winner = other_req(last_grant);
      end else if (req1) begin
         winner = REQ_M1;
      end
      any_accept = reset_n & (req0 | req1);
      grant0     = any_accept & (winner == REQ_M0);
      grant1     = any_accept & (winner == REQ_M1);
   end

   // Track current owner and how many back-to-back transfers it has had
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant <= REQ_M1;
         burst_cnt  <= '0;
         fresh      <= 1'b1;
      end else if (any_accept) begin
         fresh <= 1'b0;
         if (winner == last_grant) begin
            if (burst_cnt != CNT_MAX)
               burst_cnt <= burst_cnt + 1'b1;
         end else begin
            last_grant <= winner;
            burst_cnt  <= CNT_W'(1);
         end
      end else begin
         burst_cnt <= '0;
      end
   end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// Shares one on-chip RAM port between the CPU data master and the QSPI copy
// engine; tags accepted reads so the 1-cycle read data goes to the right one.
module nios_onchip_mem_arbiter
   import nios_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = nios_mem_arb_pkg::ADDR_W,
   parameter int unsigned DATA_W    = nios_mem_arb_pkg::DATA_W,
   parameter int unsigned BE_W      = nios_mem_arb_pkg::BE_W,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   output logic              m0_waitrequest,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic              m1_waitrequest,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic    req0, req1;
   logic    grant0, grant1;
   logic    rd_accept;
   logic    rdv_q;
   req_id_t rdv_owner;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   nios_mem_arb_grant #(
      .MAX_BURST (MAX_BURST)
   ) u_grant (
      .clk     (clk),
      .reset_n (reset_n),
      .req0    (req0),
      .req1    (req1),
      .grant0  (grant0),
      .grant1  (grant1)
   );

   // Steer the granted requester onto the RAM port; write beats read
   always_comb begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      if (grant1) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
      end
      mem_chipselect = grant0 | grant1;
      mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
      rd_accept      = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
   end

   // Remember which master owns the read data arriving next cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdv_q     <= 1'b0;
         rdv_owner <= REQ_M0;
      end else begin
         rdv_q <= rd_accept;
         if (rd_accept)
            rdv_owner <= grant1 ? REQ_M1 : REQ_M0;
      end
   end

   assign m0_waitrequest   = ~grant0;
   assign m1_waitrequest   = ~grant1;
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rdv_q & reset_n & (rdv_owner == REQ_M0);
   assign m1_readdatavalid = rdv_q & reset_n & (rdv_owner == REQ_M1);

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// Bench for nios_onchip_mem_arbiter: table vectors, directed corner cases and
// random traffic against a behavioural arbitration/memory model.
module tb_nios_onchip_mem_arbiter;

   localparam int MAXB = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [12:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        m0_waitrequest, m1_waitrequest;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write;
   logic [31:0] mem_writedata, mem_readdata;

   always #5 clk = ~clk;

   nios_onchip_mem_arbiter #(
      .ADDR_W    (13),
      .DATA_W    (32),
      .BE_W      (4),
      .MAX_BURST (MAXB)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m0_waitrequest   (m0_waitrequest),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .m1_waitrequest   (m1_waitrequest),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_readdata     (mem_readdata)
   );

   // RAM fixture: registered address, unregistered q, byte-lane writes
   bit [31:0]   ram [0:8191];
   bit [12:0]   addr_q;
   logic        pl_en = 1'b0;
   logic [12:0] pl_addr = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end else if (mem_chipselect) begin
         addr_q <= mem_address;
         if (mem_write)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b])
                  ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
   end
   assign mem_readdata = ram[addr_q];

   // Reference model state: owner 0 = nobody since reset, 1 = M0, 2 = M1
   bit [31:0]   shadow [0:8191];
   int          owner = 0;
   int          run = 0;
   int          pend = 0;
   logic [31:0] pend_data = '0;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: drive, check against the model at negedge, advance model
   task automatic cycle(input logic rst, input logic r0, input logic w0,
                        input logic r1, input logic w1,
                        input logic [12:0] a0, input logic [12:0] a1,
                        input logic [3:0] be0, input logic [3:0] be1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        output int g_obs, output logic v0, output logic v1,
                        output logic [31:0] rdata);
      int          g;
      logic        q0, q1, wr;
      logic [12:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      reset_n = rst;
      m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
      m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
      @(negedge clk);
      q0 = r0 | w0;
      q1 = r1 | w1;
      if (!rst || (!q0 && !q1)) g = 0;
      else if (q0 && !q1)       g = 1;
      else if (q1 && !q0)       g = 2;
      else if (owner == 0)      g = 1;
      else if (run < MAXB)      g = owner;
      else                      g = 3 - owner;
      g_obs = (m0_waitrequest === 1'b0 ? 1 : 0) + (m1_waitrequest === 1'b0 ? 2 : 0);
      v0    = m0_readdatavalid;
      v1    = m1_readdatavalid;
      rdata = v1 ? m1_readdata : m0_readdata;
      wr = (g == 1) ? w0 : (g == 2) ? w1 : 1'b0;
      a  = (g == 2) ? a1 : a0;
      be = (g == 2) ? be1 : be0;
      d  = (g == 2) ? d1 : d0;
      chk("grant", g_obs, g);
      chk("mem_chipselect", 32'(mem_chipselect), 32'(g != 0));
      chk("mem_write", 32'(mem_write), 32'(wr));
      if (g != 0) begin
         chk("mem_address", 32'(mem_address), 32'(a));
         if (wr) begin
            chk("mem_byteenable", 32'(mem_byteenable), 32'(be));
            chk("mem_writedata", mem_writedata, d);
         end
      end
      chk("m0_readdatavalid", 32'(v0), 32'(rst && pend == 1));
      chk("m1_readdatavalid", 32'(v1), 32'(rst && pend == 2));
      if (rst && pend != 0)
         chk("readdata", (pend == 1) ? m0_readdata : m1_readdata, pend_data);
      if (!rst) begin
         owner = 0; run = 0; pend = 0;
      end else begin
         pend = 0;
         if (g != 0) begin
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
            end else begin
               pend = g;
               pend_data = shadow[a];
            end
            if (g == owner) begin
               if (run < MAXB) run++;
            end else begin
               owner = g;
               run = 1;
            end
         end else begin
            run = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [12:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      shadow[a] = d;
      @(posedge clk);
      #1;
      pl_en = 1'b0;
   endtask

   typedef struct {
      int rst, r0, w0, r1, w1;
      int reps;
      int exp_g;
   } vec_t;

   vec_t        tbl [11];
   int          g;
   logic        v0, v1;
   logic [31:0] rd;
   logic [12:0] ra0, ra1;

   initial begin
      tbl[0]  = '{0, 1, 0, 0, 1, 3, 0};  // in reset: no grants
      tbl[1]  = '{1, 1, 0, 1, 0, 8, 1};  // M0 wins first contested cycle
      tbl[2]  = '{1, 1, 0, 1, 0, 8, 2};
      tbl[3]  = '{1, 1, 0, 1, 0, 8, 1};
      tbl[4]  = '{1, 0, 0, 0, 0, 2, 0};  // idle clears the run
      tbl[5]  = '{1, 1, 0, 1, 0, 8, 1};  // owner M0 retained, fresh run
      tbl[6]  = '{1, 1, 0, 1, 0, 1, 2};
      tbl[7]  = '{1, 0, 0, 1, 0, 3, 2};  // M1 alone extends its run
      tbl[8]  = '{1, 1, 0, 1, 0, 4, 2};
      tbl[9]  = '{1, 1, 0, 1, 0, 1, 1};
      tbl[10] = '{1, 0, 0, 0, 0, 1, 0};

      reset_n = 1'b0;
      m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
      m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
      @(posedge clk);
      #1;
      preload(13'h0010, 32'hDEADBEEF);
      preload(13'h1FFF, 32'hAABBCCDD);

      // Table: reset behaviour, contention pattern and run handling
      for (int i = 0; i < 11; i++)
         for (int k = 0; k < tbl[i].reps; k++) begin
            cycle(tbl[i].rst != 0, tbl[i].r0 != 0, tbl[i].w0 != 0, tbl[i].r1 != 0, tbl[i].w1 != 0,
                  13'h0020, 13'h0040, 4'hF, 4'hF, 32'h0, 32'h0, g, v0, v1, rd);
            chk($sformatf("tbl%0d_grant", i), g, tbl[i].exp_g);
         end

      // Single-master read with 1-cycle return
      cycle(1, 1, 0, 0, 0, 13'h0010, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      chk("rd_grant", g, 1);
      cycle(1, 0, 0, 0, 0, 13'h0, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      chk("rd_valid0", 32'(v0), 1);
      chk("rd_valid1", 32'(v1), 0);
      chk("rd_data", rd, 32'hDEADBEEF);

      // Byte write at top address, then read back immediately
      cycle(1, 0, 0, 0, 1, 13'h0, 13'h1FFF, 4'hF, 4'b0010, 0, 32'h11223344, g, v0, v1, rd);
      chk("bw_grant", g, 2);
      cycle(1, 1, 0, 0, 0, 13'h1FFF, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      cycle(1, 0, 0, 0, 0, 13'h0, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      chk("bw_valid", 32'(v0), 1);
      chk("bw_data", rd, 32'hAABB33DD);

      // Read and write together: the write is performed, no read return
      cycle(1, 1, 1, 0, 0, 13'h0030, 13'h0, 4'hF, 4'hF, 32'h5A5A5A5A, 0, g, v0, v1, rd);
      cycle(1, 0, 0, 0, 0, 13'h0, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      chk("rw_no_valid", 32'(v0), 0);
      cycle(1, 1, 0, 0, 0, 13'h0030, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      cycle(1, 0, 0, 0, 0, 13'h0, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      chk("rw_data", rd, 32'h5A5A5A5A);

      // Reset right after an accepted read squashes its return
      cycle(1, 1, 0, 0, 0, 13'h0010, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      cycle(0, 0, 0, 0, 0, 13'h0, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
      chk("rst_squash", 32'(v0), 0);
      for (int k = 0; k < 2; k++) begin
         cycle(1, 0, 0, 0, 0, 13'h0, 13'h0, 4'hF, 4'hF, 0, 0, g, v0, v1, rd);
         chk("rst_no_late_valid", 32'(v0 | v1), 0);
      end

      // Random traffic over a small address pool to provoke hazards
      for (int n = 0; n < 800; n++) begin
         ra0 = ($urandom_range(0, 4) == 0) ? 13'h1FFF : 13'($urandom_range(0, 7));
         ra1 = ($urandom_range(0, 4) == 0) ? 13'h1FFF : 13'($urandom_range(0, 7));
         cycle($urandom_range(0, 63) != 0,
               $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
               ra0, ra1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               $urandom(), $urandom(), g, v0, v1, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nios_onchip_mem_arbiter.md
Name: nios_onchip_mem_arbiter

Overview:
Shares one 32-bit x 8192-word port of the on-chip RAM (s2) between two Avalon-MM requesters.
- M0: CPU data-side master.
- M1: QSPI flash copy engine.
Arbitration is sticky with a fairness limit: the current owner keeps the port, up to MAX_BURST back-to-back transfers, while the other requester waits. The block tags each accepted read and returns read data with readdatavalid after the RAM's fixed 1-cycle read latency (registered address, unregistered q).

Parameters:
ADDR_W, 13, word address width
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
MAX_BURST, 8, max consecutive grants to one requester while the other requests; legal range 1..255

Ports:
clk  in  1  single clock for all logic and the RAM port
reset_n  in  1  synchronous, active-low reset
m0_address  in  ADDR_W  M0 word address
m0_byteenable  in  BE_W  M0 byte lanes
m0_read  in  1  M0 read request
m0_write  in  1  M0 write request
m0_writedata  in  DATA_W  M0 write data
m0_readdata  out  DATA_W  M0 read data
m0_readdatavalid  out  1  M0 read data valid
m0_waitrequest  out  1  M0 stall
m1_* (same 8 signals as m0_*) for M1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
Clocking and reset
- One clock, clk; reset is synchronous and active-low on reset_n.
- All state updates on the rising edge of clk.
- While reset_n = 0:
  - m0_waitrequest = m1_waitrequest = 1.
  - mem_chipselect = mem_write = 0.
  - m*_readdatavalid = 0, forced combinationally: rdv output = rdv_q & reset_n.
  - last_grant <= M1 (so M0 wins the first contested cycle); burst_cnt <= 0; rdv_q <= 0.
- Reset mid-operation: a pending read return is squashed. Stalled requests are dropped, not queued.

Requests and grant
- Request: req_i = m_i_read | m_i_write. If both are asserted, write wins; read is ignored that cycle.
- Grant is combinational in the same cycle:
  - Only one requester asserting: grant it.
  - Both asserting: grant last_grant if burst_cnt < MAX_BURST, else grant the other requester.
- m_i_waitrequest = ~grant_i. It is 1 for a non-requesting master.
- Accept: grant_i & req_i.

Memory port
- mem_* address, byteenable and writedata are muxed from the granted requester.
- mem_chipselect = any accept.
- mem_write = accepted write.
- Data lines are don't-care when chipselect = 0.

Burst counter
- On accept by the same requester as last_grant: burst_cnt++ (saturates at MAX_BURST).
- On accept by the other requester: burst_cnt <= 1 and last_grant <= that requester.
- Cycle with no accept: burst_cnt <= 0; last_grant is held.

Read return
- Read accepted in cycle N: m_i_readdatavalid = 1 in cycle N+1, with m_i_readdata = mem_readdata.
- Implemented as a registered tag: rdv_q plus owner.
- Both m*_readdata outputs carry mem_readdata; only the tagged master sees valid.
- Back-to-back reads at 1/clk are supported, including alternating owners.
- Write accepted in N followed by a read of the same address in N+1 returns the new data.

Throughput
- Zero bubble: one transfer per cycle whenever any request is present.

Decomposition:
- Package nios_mem_arb_pkg:
  - ADDR_W / DATA_W / BE_W constants.
  - Requester id type (REQ_M0 = 0, REQ_M1 = 1).
  - Burst counter width = clog2(MAX_BURST+1).
- Sub-module nios_mem_arb_grant: combinational grant plus last_grant/burst_cnt registers.
- The top level holds the mux and the read-return tag register.

Test Plan:
1. Reset: hold reset_n = 0 with m0_read = m1_write = 1 -> waitrequest 1/1, mem_chipselect = 0, readdatavalid 0. First cycle after release -> M0 granted.
2. Single-master read: M0 reads addr 0x0010 holding 0xDEADBEEF -> accepted cycle N; m0_readdatavalid = 1 with data 0xDEADBEEF in N+1; m1_readdatavalid stays 0.
3. Contention, MAX_BURST = 8: M0 and M1 stream reads continuously -> grant pattern M0 x8, M1 x8, M0 x8; no idle cycles; each readdatavalid tagged to the correct master.
4. Byte write: M1 writes 0x11223344, be = 4'b0010, to 0x1FFF (top address) -> M0 read next cycle returns 0xXXXX33XX with other bytes unchanged.
5. Read + write both asserted on M0 -> write performed, no readdatavalid. Idle cycle between bursts -> burst_cnt cleared; owner retained.
6. Reset mid-read: reset_n low in cycle N+1 after a read accepted in N -> m0_readdatavalid = 0 in N+1; no data return after release.
